// File: rtl/g17_seq_detector.sv
// g17_seq_detector
//   Serial pattern detector for the s27 g17 output stream. On each enabled
//   rising clock edge it shifts in one bit. It flags a match when the last
//   PATTERN_LEN samples equal PATTERN, where the MSB is the oldest sample.
//   Matches may overlap.
//
// Parameters
//   PATTERN_LEN : window length in bits (2..16)
//   PATTERN     : target pattern, MSB oldest / LSB newest
//   CNT_W       : width of the saturating match counter
//
// Ports
//   clk       in   rising-edge clock (shared with s27)
//   r         in   synchronous active-high reset
//   en        in   sample enable; din is taken only when en=1
//   clr       in   synchronous soft clear (same effect as reset)
//   din       in   serial data in (s27 g17)
//   match     out  one-cycle pulse after the edge that completed PATTERN
//   match_cnt out  number of matches, saturating at 2^CNT_W-1
//   seen      out  sticky flag, set on the first match
//   armed     out  window holds PATTERN_LEN valid samples
//
// Priority is r > clr > en. All outputs come straight from registers.
module g17_seq_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     CNT_W       = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             seen,
    output logic             armed
);

    localparam int               FILL_W    = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // The oldest sample leaves the window on the same edge that it takes part
    // in the comparison. Because of that, only PATTERN_LEN-1 samples must be
    // kept between edges.
    logic [PATTERN_LEN-2:0] hist_reg,  hist_next;
    logic [FILL_W-1:0]      fill_reg,  fill_next;
    logic                   match_reg, match_next;
    logic [CNT_W-1:0]       cnt_reg,   cnt_next;
    logic                   seen_reg,  seen_next;

    // This is the complete window as it will look after din is accepted on
    // the current edge. The match decision uses this next-state value, so the
    // registered match lines up with the sample that completed the pattern.
    logic [PATTERN_LEN-1:0] window;

    assign window[0] = din;
    generate
        for (genvar gi = 1; gi < PATTERN_LEN; gi++) begin : g_window
            assign window[gi] = hist_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (r) begin
            state_reg <= S_FILL;
            hist_reg  <= '0;
            fill_reg  <= '0;
            match_reg <= 1'b0;
            cnt_reg   <= '0;
            seen_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            cnt_reg   <= cnt_next;
            seen_reg  <= seen_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        match_next = 1'b0;          // a pulse: low unless this edge completes a match
        cnt_next   = cnt_reg;
        seen_next  = seen_reg;

        if (clr) begin
            // A soft clear drops any partial history. A pattern that straddles
            // the clear therefore needs PATTERN_LEN fresh samples.
            state_next = S_FILL;
            hist_next  = '0;
            fill_next  = '0;
            cnt_next   = '0;
            seen_next  = 1'b0;
        end else if (en) begin
            hist_next = window[PATTERN_LEN-2:0];
            if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_W'(1);
            end

            case (state_reg)
                S_FILL:  if (fill_next == FILL_FULL) state_next = S_ARMED;
                S_ARMED: state_next = S_ARMED;
                default: state_next = S_FILL;
            endcase

            // The fill guard stops a match on the zeros left behind by a reset.
            match_next = (fill_next == FILL_FULL) && (window == PATTERN);
            if (match_next) begin
                seen_next = 1'b1;
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign match     = match_reg;
    assign match_cnt = cnt_reg;
    assign seen      = seen_reg;
    assign armed     = (state_reg == S_ARMED);

endmodule

// File: tb/tb_g17_seq_detector.sv
module tb_g17_seq_detector;

    logic clk = 1'b0;
    logic r   = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic din = 1'b0;

    // Default instance: PATTERN=1011, CNT_W=8
    logic       d_match, d_seen, d_armed;
    logic [7:0] d_cnt;
    // Fill-guard instance: PATTERN=0001
    logic       p_match, p_seen, p_armed;
    logic [7:0] p_cnt;
    // Saturation instance: CNT_W=2
    logic       s_match, s_seen, s_armed;
    logic [1:0] s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    g17_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_def (
        .clk(clk), .r(r), .en(en), .clr(clr), .din(din),
        .match(d_match), .match_cnt(d_cnt), .seen(d_seen), .armed(d_armed)
    );

    g17_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b0001), .CNT_W(8)) u_p1 (
        .clk(clk), .r(r), .en(en), .clr(clr), .din(din),
        .match(p_match), .match_cnt(p_cnt), .seen(p_seen), .armed(p_armed)
    );

    g17_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
        .clk(clk), .r(r), .en(en), .clr(clr), .din(din),
        .match(s_match), .match_cnt(s_cnt), .seen(s_seen), .armed(s_armed)
    );

    // One edge: drive the inputs, wait for the rising edge, then sample 1ns later.
    task automatic tick(input logic rr, input logic ee, input logic cc, input logic dd);
        r = rr; en = ee; clr = cc; din = dd;
        @(posedge clk);
        #1;
        $display("t=%0t r=%0b en=%0b clr=%0b din=%0b | def m=%0b c=%0d s=%0b a=%0b | p1 m=%0b c=%0d a=%0b | sat m=%0b c=%0d s=%0b",
                 $time, rr, ee, cc, dd, d_match, d_cnt, d_seen, d_armed,
                 p_match, p_cnt, p_armed, s_match, s_cnt, s_seen);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [3:0] mwin;
    int         mfill, mcnt;
    logic       mseen, mexp, e, d;
    logic [6:0] ovl_stream, ovl_match;

    initial begin
        // ---- 1. reset then basic detect ----
        tick(1, 0, 0, 0);
        chk("rst_match", {31'd0, d_match}, 0);
        chk("rst_cnt",   {24'd0, d_cnt},   0);
        chk("rst_seen",  {31'd0, d_seen},  0);
        chk("rst_armed", {31'd0, d_armed}, 0);
        tick(0, 1, 0, 1); chk("b1_match", {31'd0, d_match}, 0);
        tick(0, 1, 0, 0); chk("b2_match", {31'd0, d_match}, 0);
        tick(0, 1, 0, 1); chk("b3_match", {31'd0, d_match}, 0);
        chk("b3_armed", {31'd0, d_armed}, 0);
        tick(0, 1, 0, 1);
        chk("b4_match", {31'd0, d_match}, 1);
        chk("b4_cnt",   {24'd0, d_cnt},   1);
        chk("b4_seen",  {31'd0, d_seen},  1);
        chk("b4_armed", {31'd0, d_armed}, 1);
        tick(0, 0, 0, 1);
        chk("b5_pulse_end", {31'd0, d_match}, 0);
        chk("b5_cnt_hold",  {24'd0, d_cnt},   1);

        // ---- 2. overlap: 1,0,1,1,0,1,1 -> hits after samples 4 and 7 ----
        tick(1, 0, 0, 0);
        ovl_stream = 7'b1011011;   // bit 6 is fed first
        ovl_match  = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            tick(0, 1, 0, ovl_stream[i]);
            chk($sformatf("ovl_match_%0d", 7 - i), {31'd0, d_match}, {31'd0, ovl_match[i]});
        end
        chk("ovl_cnt", {24'd0, d_cnt}, 2);

        // ---- 3. fill guard with PATTERN=0001 ----
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 1);
        chk("fg_match1", {31'd0, p_match}, 0);
        chk("fg_armed1", {31'd0, p_armed}, 0);
        tick(0, 1, 0, 0); chk("fg_match2", {31'd0, p_match}, 0);
        tick(0, 1, 0, 0); chk("fg_match3", {31'd0, p_match}, 0);
        tick(0, 1, 0, 0); chk("fg_match4", {31'd0, p_match}, 0);
        chk("fg_armed4", {31'd0, p_armed}, 1);
        tick(0, 1, 0, 1);
        chk("fg_match5", {31'd0, p_match}, 1);
        chk("fg_cnt",    {24'd0, p_cnt},   1);

        // ---- 4. enable gating and clear ----
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 1);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 1); chk("gate_m1", {31'd0, d_match}, 0);
        tick(0, 0, 0, 0); chk("gate_m2", {31'd0, d_match}, 0);
        tick(0, 0, 0, 1); chk("gate_m3", {31'd0, d_match}, 0);
        chk("gate_armed", {31'd0, d_armed}, 0);
        tick(0, 1, 0, 1); chk("gate_m4", {31'd0, d_match}, 0);
        tick(0, 1, 0, 1);
        chk("gate_hit", {31'd0, d_match}, 1);
        chk("gate_cnt", {24'd0, d_cnt},   1);
        tick(0, 0, 0, 0);
        chk("gate_en0_match", {31'd0, d_match}, 0);
        chk("gate_en0_seen",  {31'd0, d_seen},  1);
        chk("gate_en0_armed", {31'd0, d_armed}, 1);
        tick(0, 1, 1, 1);
        chk("clr_match", {31'd0, d_match}, 0);
        chk("clr_cnt",   {24'd0, d_cnt},   0);
        chk("clr_seen",  {31'd0, d_seen},  0);
        chk("clr_armed", {31'd0, d_armed}, 0);
        // If the clr-cycle 1 had been kept, 0,1,1 would complete 1011.
        tick(0, 1, 0, 0); chk("disc_m1", {31'd0, d_match}, 0);
        tick(0, 1, 0, 1); chk("disc_m2", {31'd0, d_match}, 0);
        tick(0, 1, 0, 1); chk("disc_m3", {31'd0, d_match}, 0);
        chk("disc_armed", {31'd0, d_armed}, 0);

        // ---- 5. saturation with CNT_W=2: 1011 x5 -> hits on every 4th sample ----
        tick(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 0, 1); chk($sformatf("sat_m_%0d_0", k), {31'd0, s_match}, 0);
            tick(0, 1, 0, 0); chk($sformatf("sat_m_%0d_1", k), {31'd0, s_match}, 0);
            tick(0, 1, 0, 1); chk($sformatf("sat_m_%0d_2", k), {31'd0, s_match}, 0);
            tick(0, 1, 0, 1);
            chk($sformatf("sat_hit_%0d", k), {31'd0, s_match}, 1);
            chk($sformatf("sat_cnt_%0d", k), {30'd0, s_cnt}, (k < 3) ? k + 1 : 3);
            chk($sformatf("sat_seen_%0d", k), {31'd0, s_seen}, 1);
        end

        // ---- 6. pseudo-random stream against a reference model, then mid-run reset ----
        tick(1, 0, 0, 0);
        mwin = 4'd0; mfill = 0; mcnt = 0; mseen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            e = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 2) != 0);
            mexp = 1'b0;
            if (e) begin
                mwin = {mwin[2:0], d};
                if (mfill < 4) mfill++;
                mexp = (mfill == 4) && (mwin == 4'b1011);
                if (mexp) begin
                    mseen = 1'b1;
                    if (mcnt < 255) mcnt++;
                end
            end
            tick(0, e, 0, d);
            chk($sformatf("rnd_match_%0d", i), {31'd0, d_match}, {31'd0, mexp});
        end
        chk("rnd_cnt",   {24'd0, d_cnt},   mcnt);
        chk("rnd_seen",  {31'd0, d_seen},  {31'd0, mseen});
        chk("rnd_armed", {31'd0, d_armed}, (mfill == 4) ? 1 : 0);
        tick(1, 1, 0, 1);
        chk("mid_rst_match", {31'd0, d_match}, 0);
        chk("mid_rst_cnt",   {24'd0, d_cnt},   0);
        chk("mid_rst_seen",  {31'd0, d_seen},  0);
        chk("mid_rst_armed", {31'd0, d_armed}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
